// File: rtl/sd_slot_pkg.sv
// Shared types and register map for the SD slot controller.
// State codes are architectural: firmware reads them from STATUS[6:4].
package sd_slot_pkg;

    typedef enum logic [2:0] {
        S_EMPTY   = 3'd0,
        S_DEB_IN  = 3'd1,
        S_POWERUP = 3'd2,
        S_READY   = 3'd3,
        S_DEB_OUT = 3'd4,
        S_PWROFF  = 3'd5
    } slot_state_t;

    localparam logic [1:0] REG_STATUS = 2'd0;
    localparam logic [1:0] REG_CTRL   = 2'd1;

    localparam int ST_INS_EV    = 0;
    localparam int ST_REM_EV    = 1;
    localparam int ST_READY     = 2;
    localparam int ST_PRESENT   = 3;
    localparam int ST_STATE_LSB = 4;

    localparam int CT_INS_IE  = 0;
    localparam int CT_REM_IE  = 1;
    localparam int CT_PWR_CYC = 2;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset_l,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    // NOTE: non-blocking assignments so the second flop takes the first flop's pre-edge value.
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/sd_slot_ctrl.sv
// SD socket controller: debounced card detect, power sequencing, SPI chip-select gating,
// and a small register block with W1C insert/remove events.
module sd_slot_ctrl
    import sd_slot_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int SETTLE_CYCLES   = 1000000,
    parameter int OFF_CYCLES      = 250000
) (
    input  logic        clk,
    input  logic        reset_l,
    input  logic        select,
    input  logic [1:0]  addr,
    input  logic [3:0]  we,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq,
    input  logic        sd_present_l,
    output logic        sd_power_en,
    input  logic        spi_cs_l,
    output logic        sd_cs_l
);

    localparam int CNT_MAX = max3(DEBOUNCE_CYCLES, SETTLE_CYCLES, OFF_CYCLES);
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SET_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] OFF_LAST = CNT_W'(OFF_CYCLES - 1);

    slot_state_t      r_state;
    slot_state_t      w_next;
    logic [CNT_W-1:0] r_cnt;
    logic             w_present;
    logic             w_counting;
    logic             w_ins_set;
    logic             w_rem_set;
    logic             r_ins_ev;
    logic             r_rem_ev;
    logic             r_ins_ie;
    logic             r_rem_ie;
    logic             r_irq;
    logic             w_wr_status;
    logic             w_wr_ctrl;
    logic             w_pwr_req;
    logic             w_unused;

    sync_2ff #(.RESET_VAL(1'b0)) u_present_sync (
        .clk     (clk),
        .reset_l (reset_l),
        .i_d     (~sd_present_l),
        .o_q     (w_present)
    );

    assign w_wr_status = select & we[0] & (addr == REG_STATUS);
    assign w_wr_ctrl   = select & we[0] & (addr == REG_CTRL);
    assign w_pwr_req   = w_wr_ctrl & wdata[CT_PWR_CYC];
    assign w_unused    = &{1'b0, we[3:1], wdata[31:3]};

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) r_state <= S_EMPTY;
        else          r_state <= w_next;
    end

    // NOTE: every output of this block is defaulted first so no path through the case infers a latch.
    always_comb begin
        w_next      = r_state;
        w_counting  = 1'b0;
        w_ins_set   = 1'b0;
        w_rem_set   = 1'b0;
        sd_power_en = 1'b0;
        sd_cs_l     = 1'b1;
        case (r_state)
            S_EMPTY: begin
                if (w_present) w_next = S_DEB_IN;
            end
            S_DEB_IN: begin
                w_counting = 1'b1;
                if (!w_present)             w_next = S_EMPTY;
                else if (r_cnt == DEB_LAST) w_next = S_POWERUP;
            end
            S_POWERUP: begin
                w_counting  = 1'b1;
                sd_power_en = 1'b1;
                if (!w_present) begin
                    w_next = S_EMPTY;
                end else if (r_cnt == SET_LAST) begin
                    w_next    = S_READY;
                    w_ins_set = 1'b1;
                end
            end
            S_READY: begin
                sd_power_en = 1'b1;
                sd_cs_l     = spi_cs_l;
                if (!w_present)     w_next = S_DEB_OUT;
                else if (w_pwr_req) w_next = S_PWROFF;
            end
            S_DEB_OUT: begin
                // The card keeps power and bus access until the removal is confirmed.
                w_counting  = 1'b1;
                sd_power_en = 1'b1;
                sd_cs_l     = spi_cs_l;
                if (w_present) begin
                    w_next = S_READY;
                end else if (r_cnt == DEB_LAST) begin
                    w_next    = S_EMPTY;
                    w_rem_set = 1'b1;
                end
            end
            S_PWROFF: begin
                w_counting = 1'b1;
                if (r_cnt == OFF_LAST) w_next = w_present ? S_POWERUP : S_EMPTY;
            end
            default: w_next = S_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l)                            r_cnt <= '0;
        else if (w_next != r_state)              r_cnt <= '0;
        else if (w_counting && (r_cnt != '1))    r_cnt <= r_cnt + CNT_W'(1);
    end

    // A new event takes priority over a W1C landing in the same cycle.
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            r_ins_ev <= 1'b0;
            r_rem_ev <= 1'b0;
            r_ins_ie <= 1'b0;
            r_rem_ie <= 1'b0;
            r_irq    <= 1'b0;
        end else begin
            r_ins_ev <= w_ins_set | (r_ins_ev & ~(w_wr_status & wdata[ST_INS_EV]));
            r_rem_ev <= w_rem_set | (r_rem_ev & ~(w_wr_status & wdata[ST_REM_EV]));
            if (w_wr_ctrl) begin
                r_ins_ie <= wdata[CT_INS_IE];
                r_rem_ie <= wdata[CT_REM_IE];
            end
            r_irq <= (r_ins_ev & r_ins_ie) | (r_rem_ev & r_rem_ie);
        end
    end

    assign irq = r_irq;

    always_comb begin
        rdata = '0;
        case (addr)
            REG_STATUS: begin
                rdata[ST_INS_EV]             = r_ins_ev;
                rdata[ST_REM_EV]             = r_rem_ev;
                rdata[ST_READY]              = (r_state == S_READY);
                rdata[ST_PRESENT]            = w_present;
                rdata[ST_STATE_LSB +: 3]     = r_state;
            end
            REG_CTRL: begin
                rdata[CT_INS_IE] = r_ins_ie;
                rdata[CT_REM_IE] = r_rem_ie;
            end
            default: rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_sd_slot_ctrl.sv
// Self-checking bench for sd_slot_ctrl: directed vector table, multi-cycle corner
// sequences, and a randomized run against a dwell-time reference model.
module tb_sd_slot_ctrl;

    localparam int D = 4;
    localparam int S = 8;
    localparam int O = 6;

    localparam logic [2:0] C_EMPTY   = 3'd0;
    localparam logic [2:0] C_DEB_IN  = 3'd1;
    localparam logic [2:0] C_POWERUP = 3'd2;
    localparam logic [2:0] C_READY   = 3'd3;
    localparam logic [2:0] C_DEB_OUT = 3'd4;
    localparam logic [2:0] C_PWROFF  = 3'd5;

    logic        clk = 1'b0;
    logic        reset_l = 1'b0;
    logic        select = 1'b0;
    logic [1:0]  addr = 2'd0;
    logic [3:0]  we = 4'd0;
    logic [31:0] wdata = 32'd0;
    logic [31:0] rdata;
    logic        irq;
    logic        sd_present_l = 1'b1;
    logic        sd_power_en;
    logic        spi_cs_l = 1'b1;
    logic        sd_cs_l;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sd_slot_ctrl #(
        .DEBOUNCE_CYCLES (D),
        .SETTLE_CYCLES   (S),
        .OFF_CYCLES      (O)
    ) dut (
        .clk          (clk),
        .reset_l      (reset_l),
        .select       (select),
        .addr         (addr),
        .we           (we),
        .wdata        (wdata),
        .rdata        (rdata),
        .irq          (irq),
        .sd_present_l (sd_present_l),
        .sd_power_en  (sd_power_en),
        .spi_cs_l     (spi_cs_l),
        .sd_cs_l      (sd_cs_l)
    );

    typedef struct {
        logic       pin_l;
        logic       spi;
        int         delta;
        logic       e_pwr;
        logic       e_cs;
        logic [2:0] e_state;
        logic       e_ins;
        logic       e_irq;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        if (n == 0) begin
            #1;
        end else begin
            repeat (n) @(posedge clk);
            @(negedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        select = 1'b1;
        we     = 4'b0001;
        addr   = a;
        wdata  = d;
        @(posedge clk);
        @(negedge clk);
        select = 1'b0;
        we     = 4'd0;
        wdata  = 32'd0;
        #1;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] v);
        addr = a;
        #1;
        v = rdata;
    endtask

    task automatic do_reset();
        reset_l      = 1'b0;
        select       = 1'b0;
        we           = 4'd0;
        addr         = 2'd0;
        wdata        = 32'd0;
        sd_present_l = 1'b1;
        spi_cs_l     = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset_l = 1'b1;
        #1;
    endtask

    // Reference model: tracks how long the slot has dwelt in each phase, in whole cycles.
    int   m_mode;
    int   m_dwell;
    logic m_s1, m_pres, m_ins, m_rem, m_ie_i, m_ie_r, m_irq;

    task automatic model_reset();
        m_mode = 0; m_dwell = 0;
        m_s1 = 0; m_pres = 0; m_ins = 0; m_rem = 0;
        m_ie_i = 0; m_ie_r = 0; m_irq = 0;
    endtask

    task automatic model_edge(input logic pin_l, input logic w, input logic [1:0] wa,
                              input logic [31:0] wd);
        int   nxt;
        logic ins_set, rem_set, pc;
        nxt = m_mode; ins_set = 0; rem_set = 0;
        pc = w && (wa == 2'd1) && wd[2];
        case (m_mode)
            0: if (m_pres) nxt = 1;
            1: if (!m_pres) nxt = 0; else if (m_dwell + 1 >= D) nxt = 2;
            2: if (!m_pres) nxt = 0; else if (m_dwell + 1 >= S) begin nxt = 3; ins_set = 1; end
            3: if (!m_pres) nxt = 4; else if (pc) nxt = 5;
            4: if (m_pres) nxt = 3; else if (m_dwell + 1 >= D) begin nxt = 0; rem_set = 1; end
            5: if (m_dwell + 1 >= O) nxt = m_pres ? 2 : 0;
            default: nxt = 0;
        endcase
        m_irq = (m_ins && m_ie_i) || (m_rem && m_ie_r);
        m_ins = ins_set || (m_ins && !(w && (wa == 2'd0) && wd[0]));
        m_rem = rem_set || (m_rem && !(w && (wa == 2'd0) && wd[1]));
        if (w && (wa == 2'd1)) begin
            m_ie_i = wd[0];
            m_ie_r = wd[1];
        end
        m_dwell = (nxt == m_mode) ? m_dwell + 1 : 0;
        m_mode  = nxt;
        m_pres  = m_s1;
        m_s1    = ~pin_l;
    endtask

    initial begin
        logic [31:0] st;
        int          empties;
        int          ready_at;
        logic [2:0]  prev;

        vecs[0] = '{1'b0, 1'b1, 2, 1'b0, 1'b1, C_EMPTY,   1'b0, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 1, 1'b0, 1'b1, C_DEB_IN,  1'b0, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 3, 1'b0, 1'b1, C_DEB_IN,  1'b0, 1'b0};
        vecs[3] = '{1'b0, 1'b0, 1, 1'b1, 1'b1, C_POWERUP, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 1'b0, 7, 1'b1, 1'b1, C_POWERUP, 1'b0, 1'b0};
        vecs[5] = '{1'b0, 1'b0, 1, 1'b1, 1'b0, C_READY,   1'b1, 1'b0};
        vecs[6] = '{1'b0, 1'b1, 1, 1'b1, 1'b1, C_READY,   1'b1, 1'b1};
        vecs[7] = '{1'b0, 1'b0, 0, 1'b1, 1'b0, C_READY,   1'b1, 1'b1};

        do_reset();
        check("reset_power", 32'(sd_power_en), 32'd0);
        check("reset_cs", 32'(sd_cs_l), 32'd1);
        check("reset_irq", 32'(irq), 32'd0);
        rd(2'd0, st);
        check("reset_status", st, 32'h0);

        // Insert from reset, pin low at cycle 0.
        wr(2'd1, 32'h3);
        foreach (vecs[i]) begin
            sd_present_l = vecs[i].pin_l;
            spi_cs_l     = vecs[i].spi;
            tick(vecs[i].delta);
            rd(2'd0, st);
            check($sformatf("ins_v%0d_power", i), 32'(sd_power_en), 32'(vecs[i].e_pwr));
            check($sformatf("ins_v%0d_cs", i), 32'(sd_cs_l), 32'(vecs[i].e_cs));
            check($sformatf("ins_v%0d_state", i), 32'(st[6:4]), 32'(vecs[i].e_state));
            check($sformatf("ins_v%0d_insev", i), 32'(st[0]), 32'(vecs[i].e_ins));
            check($sformatf("ins_v%0d_irq", i), 32'(irq), 32'(vecs[i].e_irq));
        end

        wr(2'd0, 32'h1);
        rd(2'd0, st);
        check("w1c_insev", 32'(st[0]), 32'd0);
        tick(1);
        check("w1c_irq", 32'(irq), 32'd0);

        // Short high glitch while READY.
        spi_cs_l = 1'b1;
        sd_present_l = 1'b1;
        tick(2);
        sd_present_l = 1'b0;
        spi_cs_l = 1'b0;
        tick(2);
        rd(2'd0, st);
        check("glitch_state", 32'(st[6:4]), 32'(C_DEB_OUT));
        check("glitch_cs_pass", 32'(sd_cs_l), 32'd0);
        check("glitch_power", 32'(sd_power_en), 32'd1);
        tick(6);
        rd(2'd0, st);
        check("glitch_back_state", 32'(st[6:4]), 32'(C_READY));
        check("glitch_no_rem", 32'(st[1]), 32'd0);

        // Real removal.
        spi_cs_l = 1'b1;
        sd_present_l = 1'b1;
        tick(6);
        rd(2'd0, st);
        check("rem_pre_state", 32'(st[6:4]), 32'(C_DEB_OUT));
        check("rem_pre_power", 32'(sd_power_en), 32'd1);
        check("rem_pre_ev", 32'(st[1]), 32'd0);
        tick(1);
        rd(2'd0, st);
        check("rem_state", 32'(st[6:4]), 32'(C_EMPTY));
        check("rem_power", 32'(sd_power_en), 32'd0);
        check("rem_ev", 32'(st[1]), 32'd1);
        tick(1);
        check("rem_irq", 32'(irq), 32'd1);
        wr(2'd0, 32'h2);

        // Bounce on insertion.
        do_reset();
        empties  = 0;
        ready_at = -1;
        prev     = C_EMPTY;
        for (int c = 1; c <= 40; c++) begin
            sd_present_l = (c == 3);
            tick(1);
            rd(2'd0, st);
            if (prev != C_EMPTY && st[6:4] == C_EMPTY) empties++;
            if (st[6:4] == C_READY && ready_at < 0) ready_at = c;
            prev = st[6:4];
        end
        check("bounce_empty_returns", 32'(empties), 32'd1);
        check("bounce_ready_cycle", 32'(ready_at), 32'd18);

        // CPU power cycle from READY.
        wr(2'd1, 32'h3);
        wr(2'd0, 32'h3);
        spi_cs_l = 1'b0;
        wr(2'd1, 32'h7);
        rd(2'd0, st);
        check("pc_state", 32'(st[6:4]), 32'(C_PWROFF));
        check("pc_power", 32'(sd_power_en), 32'd0);
        check("pc_cs", 32'(sd_cs_l), 32'd1);
        rd(2'd1, st);
        check("pc_ctrl_read", st, 32'h3);
        tick(5);
        check("pc_off_last", 32'(sd_power_en), 32'd0);
        tick(1);
        rd(2'd0, st);
        check("pc_powerup", 32'(st[6:4]), 32'(C_POWERUP));
        check("pc_power_on", 32'(sd_power_en), 32'd1);
        tick(7);
        rd(2'd0, st);
        check("pc_settle_last", 32'(st[6:4]), 32'(C_POWERUP));
        tick(1);
        rd(2'd0, st);
        check("pc_ready", 32'(st[6:4]), 32'(C_READY));
        check("pc_insev", 32'(st[0]), 32'd1);
        check("pc_no_rem", 32'(st[1]), 32'd0);

        // Removal during POWERUP.
        wr(2'd1, 32'h7);
        tick(6);
        rd(2'd0, st);
        check("pu_rem_pre", 32'(st[6:4]), 32'(C_POWERUP));
        sd_present_l = 1'b1;
        tick(2);
        check("pu_rem_power_held", 32'(sd_power_en), 32'd1);
        tick(1);
        rd(2'd0, st);
        check("pu_rem_state", 32'(st[6:4]), 32'(C_EMPTY));
        check("pu_rem_power", 32'(sd_power_en), 32'd0);
        check("pu_rem_ev", 32'(st[1]), 32'd0);

        // Asynchronous reset while READY.
        sd_present_l = 1'b0;
        tick(20);
        rd(2'd0, st);
        check("rst_pre_ready", 32'(st[6:4]), 32'(C_READY));
        reset_l = 1'b0;
        #1;
        rd(2'd0, st);
        check("rst_power", 32'(sd_power_en), 32'd0);
        check("rst_cs", 32'(sd_cs_l), 32'd1);
        check("rst_state", 32'(st[6:4]), 32'(C_EMPTY));
        check("rst_rem", 32'(st[1]), 32'd0);
        check("rst_irq", 32'(irq), 32'd0);

        // Randomized run against the reference model.
        do_reset();
        model_reset();
        begin
            logic        pin;
            int          hold;
            logic        do_w;
            logic [1:0]  wa;
            logic [31:0] wd;
            logic [31:0] exp_st;
            pin  = 1'b1;
            hold = 0;
            for (int c = 0; c < 3000; c++) begin
                if (hold == 0) begin
                    pin  = ~pin;
                    hold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 5) : $urandom_range(10, 40);
                end
                hold--;
                do_w = ($urandom_range(0, 11) == 0);
                wa   = 2'($urandom_range(0, 3));
                wd   = 32'($urandom_range(0, 7));
                sd_present_l = pin;
                spi_cs_l     = 1'($urandom_range(0, 1));
                select       = do_w;
                we           = do_w ? 4'($urandom_range(0, 15)) : 4'd0;
                addr         = wa;
                wdata        = wd;
                model_edge(pin, select & we[0], wa, wd);
                tick(1);
                select = 1'b0;
                we     = 4'd0;
                rd(2'd0, st);
                exp_st = {25'd0, 3'(m_mode), m_pres, (m_mode == 3), m_rem, m_ins};
                check("rnd_status", st, exp_st);
                check("rnd_power", 32'(sd_power_en), 32'(m_mode >= 2 && m_mode <= 4));
                check("rnd_cs", 32'(sd_cs_l), 32'((m_mode == 3 || m_mode == 4) ? spi_cs_l : 1'b1));
                check("rnd_irq", 32'(irq), 32'(m_irq));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sd_slot_ctrl.md
# sd_slot_ctrl

Slot controller for the SD card socket: synchronises and debounces the card-detect pin and sequences card power. It gates the SPI chip-select so the SPI master only reaches a powered, settled card, and raises a maskable insert/remove interrupt. It sits on the CPU peripheral bus next to the SPI module; firmware waits for `card_ready` before starting SPI card init.

## Interface
- `DEBOUNCE_CYCLES`, default 500000: stable-level cycles required to accept an insert or a removal.
- `SETTLE_CYCLES`, default 1000000: power-on settle time before the card is declared ready.
- `OFF_CYCLES`, default 250000: minimum power-off time during a CPU-requested power cycle.
- `clk`  in  1  system clock, single domain.
- `reset_l`  in  1  asynchronous, active-low reset.
- `select`  in  1  peripheral chip-select for this block.
- `addr`  in  2  word address within the block.
- `we`  in  4  byte write enables; only `we[0]` is used.
- `wdata`  in  32  write data.
- `rdata`  out  32  read data, combinational from `addr`.
- `irq`  out  1  level interrupt.
- `sd_present_l`  in  1  raw card-detect pin, active low, asynchronous.
- `sd_power_en`  out  1  card supply enable.
- `spi_cs_l`  in  1  chip-select from the SPI master.
- `sd_cs_l`  out  1  chip-select to the card.

## Operation
- Sync: 2-flop synchroniser on `~sd_present_l` gives `present`, reset value 0.
- FSM states (Moore outputs):
  - `EMPTY`: power off, `sd_cs_l`=1. If `present`=1, go to `DEB_IN` and clear the counter.
  - `DEB_IN`: count while `present`=1. `present`=0 returns to `EMPTY`. At count `DEBOUNCE_CYCLES-1`, go to `POWERUP`.
  - `POWERUP`: power on, cs forced high. Count to `SETTLE_CYCLES-1`, then go to `READY` and set `ins_ev`. `present`=0 at any point goes straight to `EMPTY` with no event.
  - `READY`: power on, `sd_cs_l`=`spi_cs_l`. `present`=0 goes to `DEB_OUT`. A power-cycle request goes to `PWROFF`.
  - `DEB_OUT`: power on, cs pass-through. `present`=1 returns to `READY`. At count `DEBOUNCE_CYCLES-1`, go to `EMPTY` and set `rem_ev`.
  - `PWROFF`: power off, cs high. Count to `OFF_CYCLES-1`, then go to `POWERUP` if `present`=1, else `EMPTY`. `rem_ev` is not set in either case.
- Counter: one shared counter, width `$clog2(max(DEBOUNCE_CYCLES, SETTLE_CYCLES, OFF_CYCLES))`. Cleared on every state change; never wraps.
- Registers:
  - `addr` 0, STATUS (read): [0] `ins_ev`, [1] `rem_ev`, [2] `card_ready` (state==`READY`), [3] `present`, [6:4] state code, all other bits 0. Write with `select & we[0]`: 1 in `wdata[0]`/`wdata[1]` clears the matching event (W1C).
  - `addr` 1, CTRL: [0] `ins_ie`, [1] `rem_ie` are read/write. [2] is a power-cycle request: write-only, self-clearing, reads 0, ignored outside `READY`.
  - `addr` 2 and 3 read 0; writes are ignored.
- `irq` = (`ins_ev & ins_ie`) | (`rem_ev & rem_ie`), registered.
- Event set and W1C in the same cycle: set wins.

## Timing
- Reset: state `EMPTY`, counter 0, `present` 0, events 0, enables 0.
  - Outputs: `sd_power_en`=0, `sd_cs_l`=1, `irq`=0.
  - Reset mid-operation cuts power immediately (asynchronous).
- Pin edge to `present`: 2 cycles. `present` rising to `DEB_IN`: 1 cycle.
- Insert to `READY`: 3 + `DEBOUNCE_CYCLES` + `SETTLE_CYCLES` cycles.
  - `sd_power_en` rises in the first `POWERUP` cycle.
  - `ins_ev` is visible in the first `READY` cycle; `irq` follows 1 cycle later.
- Removal: `sd_cs_l` stays pass-through and power stays on until the `DEB_OUT` timeout. Power drops in the first `EMPTY` cycle.
- Register writes take effect on the next clock edge. Reads have zero latency.
- Power-cycle write in `READY`: `PWROFF` on the next cycle, with `sd_cs_l`=1 and `sd_power_en`=0 that same cycle.

## Structure
- Package `sd_slot_pkg` holds:
  - state enum with fixed 3-bit codes: `EMPTY`=0, `DEB_IN`=1, `POWERUP`=2, `READY`=3, `DEB_OUT`=4, `PWROFF`=5;
  - register offsets;
  - STATUS/CTRL bit positions.
- Sub-module `sync_2ff` (reusable, reset value parameter) implements the pin synchroniser.

## Test plan
All runs use `DEBOUNCE_CYCLES`=4, `SETTLE_CYCLES`=8, `OFF_CYCLES`=6.
- Reset release, pin high: `sd_power_en`=0, `sd_cs_l`=1, STATUS reads 0x00000000.
- Insert: pin low at cycle 0, `ins_ie`=1.
  - `sd_power_en`=1 from cycle 7.
  - `card_ready` and `ins_ev` at cycle 15; `irq` at 16.
  - `sd_cs_l` tracks `spi_cs_l`.
  - W1C 0x1 drops `irq` the next cycle.
- Bounce: pin low 2 cycles, high 1, then low steady. The FSM returns to `EMPTY` once, and `READY` occurs exactly 3+4+8 cycles after the final low edge.
- Removal in `READY`: pin high.
  - `rem_ev` after 2+1+4 cycles, power off the same cycle.
  - A 2-cycle high glitch instead returns to `READY` with no event.
- Power cycle: write CTRL=0x4 in `READY`.
  - Power is low for 6 cycles, then 8 cycles in `POWERUP`, then `READY` with a new `ins_ev`.
  - No `rem_ev` is raised.
- Removal during `POWERUP`, and `reset_l` low during `READY`: power drops (next cycle and immediately, respectively), `rem_ev` stays 0, and the state reads `EMPTY`.
